wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Shares the single writeback/ROB-completion bus between the functional units: ALU, MUL, DIV and load.
//  Each source has a small FIFO. A round-robin arbiter drains one entry per cycle onto a registered writeback bus.
//  Backpressure goes to the issue queues through src_ready. Sits between the FU outputs and the ROB/wakeup logic.
// PARAMETERS
//  NUM_SRC     4   number of requesting FUs (index 0=ALU,1=MUL,2=DIV,3=LOAD)
//  WORD_WIDTH  32  result data width
//  PDST_WIDTH  5   ROB tag width ($clog2(ROB_DEPTH))
//  BUF_DEPTH   2   entries per source FIFO (power of two, >=2)
// PORTS
//  clk        in   1                     clock
//  rst        in   1                     reset, synchronous, active-high
//  flush      in   1                     pipeline flush (mispredict/exception): discard everything
//  src_valid  in   NUM_SRC               per-source result valid
//  src_data   in   NUM_SRC*WORD_WIDTH    per-source result, source i at [i*WORD_WIDTH +: WORD_WIDTH]
//  src_pdst   in   NUM_SRC*PDST_WIDTH    per-source ROB tag, same packing
//  src_ready  out  NUM_SRC               source i may present a result this cycle
//  wb_valid   out  1                     writeback bus valid (registered)
//  wb_data    out  WORD_WIDTH            writeback result
//  wb_pdst    out  PDST_WIDTH            writeback ROB tag
//  wb_src     out  $clog2(NUM_SRC)       index of granted source
// BEHAVIOUR
//  - One clock domain (clk); rst synchronous active-high. On rst: all FIFOs empty, rr pointer=0,
//    wb_valid=0, wb_data=0, wb_pdst=0, wb_src=0, src_ready=all 1 from the following cycle.
//  - Push: on a clk edge where src_valid[i] & src_ready[i], write {data,pdst} into FIFO i.
//    src_valid[i] while !src_ready[i] is a protocol violation. Source must hold; the entry is not captured; a bench assertion flags it.
//  - src_ready[i] = (count[i] < BUF_DEPTH). Count is taken from the start of the cycle, so a full FIFO shows not-ready
//    even if it pops in the same cycle. No combinational path from wb side to src_ready.
//  - Arbitration (combinational on FIFO non-empty flags): choose the first non-empty FIFO scanning
//    rr_ptr, rr_ptr+1, ... mod NUM_SRC. Pop its head; on the next edge wb_* <= head, wb_src <= index,
//    wb_valid <= 1, and rr_ptr <= (index+1) mod NUM_SRC. If no FIFO is non-empty: wb_valid <= 0,
//    wb_data/pdst/src hold, rr_ptr unchanged.
//  - Latency: a result pushed at edge N appears on wb_* at edge N+1 at the earliest (no bypass of empty FIFO).
//  - Throughput: 1 writeback/cycle total. A source waits at most NUM_SRC-1 grants once at head.
//  - Simultaneous push and pop on the same FIFO: both take effect, count unchanged. Pointers wrap mod BUF_DEPTH.
//  - Ordering: per-source FIFO order is preserved. There is no ordering guarantee across sources.
//  - flush: on an edge with flush=1, all FIFOs empty, wb_valid <= 0, rr_ptr <= 0. Pushes in that cycle are dropped.
//    rst has priority over flush. Both take effect mid-operation with no partial drain.
//  - count[i] never exceeds BUF_DEPTH and never underflows; the bench asserts both.
// TESTING
//  1. rst held 2 cycles, then released -> wb_valid=0, src_ready=4'b1111; ALU pushes data=0x11,pdst=3 at edge 0
//     -> edge 1 wb_valid=1,wb_data=0x11,wb_pdst=3,wb_src=0; edge 2 wb_valid=0.
//  2. All four sources push once in the same cycle (data=0xA0..0xA3) -> wb_src sequence 0,1,2,3 on 4 consecutive
//     cycles, then wb_valid=0; rr_ptr returns to 0.
//  3. LOAD pushes 3 back-to-back with BUF_DEPTH=2 while ALU also streams every cycle -> src_ready[3]=0 after 2 pushes.
//     Grants alternate 0,3,0,3. Every load retires in push order.
//  4. Fill all FIFOs, assert flush for one cycle with a concurrent MUL push -> next cycle wb_valid=0,
//     src_ready=4'b1111. The MUL entry is never written back.
//  5. DIV pushes tag 7 at the same edge as rst=1 -> no writeback ever appears for tag 7. Outputs are at reset values.
//  6. Random valid traffic for 10k cycles honoring src_ready -> scoreboard: every pushed {src,pdst,data} appears exactly
//     once, per-source order kept, no source waits more than NUM_SRC-1 grants once at FIFO head.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback bus arbiter: one small FIFO per functional unit, drained round-robin
// one entry per cycle onto a registered writeback/ROB-completion bus.

module wb_arbiter_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             ready,
  output logic             nonempty
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic                    do_push, do_pop;

  // ready/nonempty come straight from the registered count, never from the pop side
  assign ready    = count < CNT_W'(DEPTH);
  assign nonempty = count != '0;
  assign do_push  = push && ready;
  assign do_pop   = pop && nonempty;
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module wb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int WORD_WIDTH = 32,
  parameter int PDST_WIDTH = 5,
  parameter int BUF_DEPTH  = 2,
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int CNT_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*WORD_WIDTH-1:0] src_data,
  input  logic [NUM_SRC*PDST_WIDTH-1:0] src_pdst,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          wb_valid,
  output logic [WORD_WIDTH-1:0]         wb_data,
  output logic [PDST_WIDTH-1:0]         wb_pdst,
  output logic [SRC_W-1:0]              wb_src
);
  typedef struct packed {
    logic [PDST_WIDTH-1:0] pdst;
    logic [WORD_WIDTH-1:0] data;
  } ent_t;
  localparam int ENT_W = $bits(ent_t);

  logic [NUM_SRC-1:0][ENT_W-1:0] head;
  logic [NUM_SRC-1:0][CNT_W-1:0] cnt;
  logic [NUM_SRC-1:0]            nonempty;
  logic [NUM_SRC-1:0]            pop;
  logic [SRC_W-1:0]              rr_ptr;
  logic [SRC_W-1:0]              gnt_idx;
  logic [SRC_W-1:0]              cand;
  logic [SRC_W-1:0]              rr_next;
  logic                          gnt_vld;
  ent_t                          head_sel;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    ent_t din;
    assign din.data = src_data[i*WORD_WIDTH +: WORD_WIDTH];
    assign din.pdst = src_pdst[i*PDST_WIDTH +: PDST_WIDTH];
    assign pop[i]   = gnt_vld && (gnt_idx == SRC_W'(i));

    wb_arbiter_fifo #(.W(ENT_W), .DEPTH(BUF_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (src_valid[i]),
      .pop      (pop[i]),
      .din      (din),
      .dout     (head[i]),
      .count    (cnt[i]),
      .ready    (src_ready[i]),
      .nonempty (nonempty[i])
    );
  end

  // First non-empty FIFO scanning upward from rr_ptr, wrapping mod NUM_SRC
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (!gnt_vld && nonempty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign rr_next  = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
  assign head_sel = ent_t'(head[gnt_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_pdst  <= '0;
      wb_src   <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      rr_ptr   <= '0;
    end else if (gnt_vld) begin
      wb_valid <= 1'b1;
      wb_data  <= head_sel.data;
      wb_pdst  <= head_sel.pdst;
      wb_src   <= gnt_idx;
      rr_ptr   <= rr_next;
    end else begin
      wb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: accepted pushes feed per-source expected queues,
// a negedge monitor pops and checks each writeback, plus directed hand-checked scenarios.

module tb_wb_arbiter;
  localparam int NS = 4, WW = 32, PW = 5, BD = 2;

  logic             clk, rst, flush;
  logic [NS-1:0]    src_valid, src_ready;
  logic [NS*WW-1:0] src_data;
  logic [NS*PW-1:0] src_pdst;
  logic             wb_valid;
  logic [WW-1:0]    wb_data;
  logic [PW-1:0]    wb_pdst;
  logic [1:0]       wb_src;

  typedef struct packed {
    logic [PW-1:0] pdst;
    logic [WW-1:0] data;
  } ent_t;

  ent_t q[NS][$];
  bit   elig[NS];
  int   wait_cnt[NS];
  int   n_cmp, n_err;
  bit   mon_en;
  int   ms, worst;
  bit   any_elig;
  ent_t me;

  wb_arbiter #(.NUM_SRC(NS), .WORD_WIDTH(WW), .PDST_WIDTH(PW), .BUF_DEPTH(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_pdst  (src_pdst),
    .src_ready (src_ready),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .wb_pdst   (wb_pdst),
    .wb_src    (wb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int s, input logic [WW-1:0] d, input logic [PW-1:0] p);
    src_valid[s] = 1'b1;
    src_data[s*WW +: WW] = d;
    src_pdst[s*PW +: PW] = p;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Input side: record accepted pushes and which FIFOs hold work at this edge
  always @(posedge clk) begin
    if (mon_en) begin
      if (rst || flush) begin
        for (int i = 0; i < NS; i++) begin
          q[i].delete();
          elig[i] = 1'b0;
          wait_cnt[i] = 0;
        end
      end else begin
        for (int i = 0; i < NS; i++) begin
          elig[i] = q[i].size() > 0;
          if (src_valid[i] && !src_ready[i]) begin
            n_cmp++;
            n_err++;
            $display("FAIL proto: src%0d valid while not ready at %0t", i, $time);
          end else if (src_valid[i]) begin
            q[i].push_back({src_pdst[i*PW +: PW], src_data[i*WW +: WW]});
          end
        end
      end
    end
  end

  // Output side: pop and compare every writeback, check fairness and occupancy
  always @(negedge clk) begin
    if (mon_en) begin
      any_elig = 1'b0;
      for (int i = 0; i < NS; i++) any_elig |= elig[i];
      chk("work_conserving", {63'd0, wb_valid | ~any_elig}, 64'd1);
      if (wb_valid) begin
        ms = int'(wb_src);
        if (q[ms].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_wb: src%0d data %0h pdst %0h expected none", ms, wb_data, wb_pdst);
        end else begin
          me = q[ms].pop_front();
          chk("wb_data", {32'd0, wb_data}, {32'd0, me.data});
          chk("wb_pdst", {59'd0, wb_pdst}, {59'd0, me.pdst});
        end
        worst = 0;
        for (int i = 0; i < NS; i++) begin
          if (i == ms) wait_cnt[i] = 0;
          else if (elig[i]) wait_cnt[i]++;
          if (wait_cnt[i] > worst) worst = wait_cnt[i];
        end
        chk("rr_wait_bound", {63'd0, worst <= NS - 1}, 64'd1);
      end
      for (int i = 0; i < NS; i++)
        chk("fifo_count", 64'(dut.cnt[i]), 64'(q[i].size()));
    end
  end

  int g[$];
  int loads;

  initial begin
    n_cmp = 0; n_err = 0; mon_en = 0;
    rst = 1'b1; flush = 1'b0;
    src_valid = '0; src_data = '0; src_pdst = '0;

    // 1: reset for 2 cycles, single ALU result
    cyc(); cyc();
    rst = 1'b0; mon_en = 1'b1;
    chk("t1_rst_valid", {63'd0, wb_valid}, 64'd0);
    chk("t1_rst_ready", {60'd0, src_ready}, 64'hF);
    drive(0, 32'h11, 5'd3);
    cyc();
    src_valid = '0;
    chk("t1_e0_valid", {63'd0, wb_valid}, 64'd0);
    cyc();
    chk("t1_e1_valid", {63'd0, wb_valid}, 64'd1);
    chk("t1_e1_data", {32'd0, wb_data}, 64'h11);
    chk("t1_e1_pdst", {59'd0, wb_pdst}, 64'd3);
    chk("t1_e1_src", {62'd0, wb_src}, 64'd0);
    cyc();
    chk("t1_e2_valid", {63'd0, wb_valid}, 64'd0);

    // 2: all four push together after a flush resets the rr pointer
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t2_rr_after_flush", {62'd0, dut.rr_ptr}, 64'd0);
    for (int s = 0; s < NS; s++) drive(s, 32'hA0 + 32'(s), 5'(s));
    cyc();
    src_valid = '0;
    chk("t2_e0_valid", {63'd0, wb_valid}, 64'd0);
    for (int k = 0; k < NS; k++) begin
      cyc();
      chk("t2_valid", {63'd0, wb_valid}, 64'd1);
      chk("t2_src", {62'd0, wb_src}, 64'(k));
      chk("t2_data", {32'd0, wb_data}, 64'hA0 + 64'(k));
    end
    cyc();
    chk("t2_idle", {63'd0, wb_valid}, 64'd0);
    chk("t2_rr_home", {62'd0, dut.rr_ptr}, 64'd0);

    // 3: LOAD pushes 3 while ALU streams; LOAD backpressures after 2
    loads = 0;
    for (int c = 0; c < 10; c++) begin
      src_valid = '0;
      if (c < 8 && src_ready[0]) drive(0, 32'hB00 + 32'(c), 5'(c));
      if (loads < 3 && src_ready[3]) begin
        drive(3, 32'hC00 + 32'(loads), 5'd16 + 5'(loads));
        loads++;
      end
      cyc();
      if (wb_valid) g.push_back(int'(wb_src));
      if (c == 1) chk("t3_load_full", {63'd0, src_ready[3]}, 64'd0);
    end
    src_valid = '0;
    repeat (10) cyc();
    chk("t3_loads_sent", 64'(loads), 64'd3);
    chk("t3_grants", {63'd0, g.size() >= 4}, 64'd1);
    if (g.size() >= 4) begin
      chk("t3_g0", 64'(g[0]), 64'd0);
      chk("t3_g1", 64'(g[1]), 64'd3);
      chk("t3_g2", 64'(g[2]), 64'd0);
      chk("t3_g3", 64'(g[3]), 64'd3);
    end

    // 4: fill the FIFOs, then flush with a concurrent MUL push
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NS; s++) drive(s, 32'hD0 + 32'(r * NS + s), 5'(8 + s));
      cyc();
    end
    src_valid = '0;
    drive(0, 32'hD8, 5'd12);
    cyc();
    src_valid = '0;
    chk("t4_mul_ready", {63'd0, src_ready[1]}, 64'd1);
    drive(1, 32'hDEAD, 5'd31);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    src_valid = '0;
    chk("t4_valid", {63'd0, wb_valid}, 64'd0);
    chk("t4_ready", {60'd0, src_ready}, 64'hF);
    repeat (6) cyc();
    chk("t4_quiet", {63'd0, wb_valid}, 64'd0);

    // 5: DIV push coinciding with reset is dropped
    drive(2, 32'h77, 5'd7);
    rst = 1'b1;
    cyc();
    src_valid = '0;
    cyc();
    rst = 1'b0;
    chk("t5_valid", {63'd0, wb_valid}, 64'd0);
    chk("t5_data", {32'd0, wb_data}, 64'd0);
    chk("t5_pdst", {59'd0, wb_pdst}, 64'd0);
    chk("t5_src", {62'd0, wb_src}, 64'd0);
    chk("t5_ready", {60'd0, src_ready}, 64'hF);
    repeat (5) cyc();
    chk("t5_quiet", {63'd0, wb_valid}, 64'd0);

    // 6: random traffic honoring src_ready
    for (int c = 0; c < 10000; c++) begin
      src_valid = '0;
      for (int s = 0; s < NS; s++)
        if (src_ready[s] && $urandom_range(0, 99) < 40)
          drive(s, $urandom, 5'($urandom_range(0, 31)));
      cyc();
    end
    src_valid = '0;
    repeat (20) cyc();
    for (int s = 0; s < NS; s++) chk("t6_drained", 64'(q[s].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
